id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_pkg.sv | 74 +++++++
 rtl/id_stage_reg_file.sv | 28 ++
 rtl/id_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared opcodes, ALU/writeback encodings and decode types for the ID stage
package id_stage_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef struct packed {
    alu_e    alu_ctrl;
    logic    alu_src_a;
    logic    alu_src_b;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    wb_sel_e wb_sel;
    logic    branch;
    logic    jump;
    logic    jalr;
    logic    illegal;
  } ctrl_t;

  // alt selects SUB/SRA (instr bit 30) where the funct3 has an alternate form
  function automatic alu_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op = ALU_SLL;
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_stage_reg_file.sv
// reg_file: 32 x WIDTH register file, x0 hardwired to zero, combinational reads with writeback bypass
module reg_file #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [4:0]       i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [4:0]       i_ra1,
  input  logic [4:0]       i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2
);
  logic [WIDTH-1:0] r_regs [32];
  logic             w_we;

  assign w_we = i_we && i_wa != '0;

  always_ff @(posedge i_clk)
    if (i_rst)
      for (int k = 0; k < 32; k++) r_regs[k] <= '0;
    else if (w_we)
      r_regs[i_wa] <= i_wd;

  assign o_rd1 = (i_ra1 == '0) ? '0 : (w_we && i_wa == i_ra1) ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : (w_we && i_wa == i_ra2) ? i_wd : r_regs[i_ra2];
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode, immediate generation, register read and ID/EX pipeline register
module id_stage
  import id_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_id_pc,
  input  logic [WIDTH-1:0] i_id_pc_plus_4,
  input  logic [WIDTH-1:0] i_id_instr,
  input  logic             i_wb_reg_write,
  input  logic [4:0]       i_wb_rd,
  input  logic [WIDTH-1:0] i_wb_data,
  input  logic             i_ex_stall,
  input  logic             i_ex_flush,
  output logic [WIDTH-1:0] o_ex_pc,
  output logic [WIDTH-1:0] o_ex_pc_plus_4,
  output logic [WIDTH-1:0] o_ex_rs1_data,
  output logic [WIDTH-1:0] o_ex_rs2_data,
  output logic [WIDTH-1:0] o_ex_imm,
  output logic [4:0]       o_ex_rs1,
  output logic [4:0]       o_ex_rs2,
  output logic [4:0]       o_ex_rd,
  output logic [2:0]       o_ex_funct3,
  output logic [3:0]       o_ex_alu_ctrl,
  output logic             o_ex_alu_src_a,
  output logic             o_ex_alu_src_b,
  output logic             o_ex_reg_write,
  output logic             o_ex_mem_read,
  output logic             o_ex_mem_write,
  output logic [1:0]       o_ex_wb_sel,
  output logic             o_ex_branch,
  output logic             o_ex_jump,
  output logic             o_ex_jalr,
  output logic             o_ex_illegal,
  output logic             o_load_use
);
  logic [31:0]      w_ins;
  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  ctrl_t            w_ctrl;
  fmt_e             w_fmt;
  logic             w_legal;
  logic [31:0]      w_imm32;
  logic [WIDTH-1:0] w_imm;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic [WIDTH-1:0] w_rs1_data;
  logic [WIDTH-1:0] w_rs2_data;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pc4;
  logic [WIDTH-1:0] r_rs1_data;
  logic [WIDTH-1:0] r_rs2_data;
  logic [WIDTH-1:0] r_imm;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [2:0]       r_f3;
  ctrl_t            r_ctrl;

  assign w_ins = i_id_instr[31:0];
  assign w_op  = w_ins[6:0];
  assign w_f3  = w_ins[14:12];
  assign w_f7  = w_ins[31:25];

  // Each opcode sets its controls and a legality flag; anything illegal is squashed to illegal-only
  always_comb begin
    w_ctrl  = '0;
    w_fmt   = FMT_NONE;
    w_legal = 1'b1;
    case (w_op)
      OP_LUI: begin
        w_fmt = FMT_U;
        w_ctrl.alu_ctrl = ALU_PASS_B;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        w_fmt = FMT_U;
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        w_fmt = FMT_J;
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel = WB_PC4;
        w_ctrl.jump = 1'b1;
      end
      OP_JALR: begin
        w_legal = w_f3 == 3'b000;
        w_fmt = FMT_I;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel = WB_PC4;
        w_ctrl.jalr = 1'b1;
      end
      OP_BRANCH: begin
        w_legal = w_f3[2:1] != 2'b01;
        w_fmt = FMT_B;
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.branch = 1'b1;
      end
      OP_LOAD: begin
        w_legal = w_f3 != 3'b011 && w_f3[2:1] != 2'b11;
        w_fmt = FMT_I;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read = 1'b1;
        w_ctrl.wb_sel = WB_MEM;
      end
      OP_STORE: begin
        w_legal = !w_f3[2] && w_f3[1:0] != 2'b11;
        w_fmt = FMT_S;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_IMM: begin
        w_legal = (w_f3 == 3'b001) ? w_f7 == 7'h00 :
                  (w_f3 == 3'b101) ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1;
        w_fmt = FMT_I;
        w_ctrl.alu_ctrl = alu_op(w_f3, w_f3 == 3'b101 && w_f7[5]);
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OP_REG: begin
        w_legal = w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101));
        w_fmt = FMT_R;
        w_ctrl.alu_ctrl = alu_op(w_f3, w_f7[5]);
        w_ctrl.reg_write = 1'b1;
      end
      OP_FENCE:  w_legal = w_f3 == 3'b000;
      OP_SYSTEM: w_legal = w_ins == INSTR_ECALL || w_ins == INSTR_EBREAK;
      default:   w_legal = w_ins == '0;
    endcase
    if (!w_legal) begin
      w_ctrl = '0;
      w_ctrl.illegal = 1'b1;
      w_fmt = FMT_NONE;
    end
  end

  always_comb
    w_imm32 = (w_fmt == FMT_I) ? {{20{w_ins[31]}}, w_ins[31:20]} :
              (w_fmt == FMT_S) ? {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]} :
              (w_fmt == FMT_B) ? {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0} :
              (w_fmt == FMT_U) ? {w_ins[31:12], 12'h000} :
              (w_fmt == FMT_J) ? {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0} :
              '0;

  assign w_imm = WIDTH'($signed(w_imm32));
  assign w_rs1 = (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? w_ins[19:15] : '0;
  assign w_rs2 = (w_fmt inside {FMT_R, FMT_S, FMT_B}) ? w_ins[24:20] : '0;
  assign w_rd  = w_ctrl.reg_write ? w_ins[11:7] : '0;

  reg_file #(.WIDTH(WIDTH)) u_reg_file (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_we  (i_wb_reg_write),
    .i_wa  (i_wb_rd),
    .i_wd  (i_wb_data),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rs1_data),
    .o_rd2 (w_rs2_data)
  );

  always_ff @(posedge i_clk)
    if (i_rst || i_ex_flush) begin
      r_pc       <= '0;
      r_pc4      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_f3       <= '0;
      r_ctrl     <= '0;
    end else if (!i_ex_stall) begin
      r_pc       <= i_id_pc;
      r_pc4      <= i_id_pc_plus_4;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_f3       <= w_f3;
      r_ctrl     <= w_ctrl;
    end

  assign o_ex_pc        = r_pc;
  assign o_ex_pc_plus_4 = r_pc4;
  assign o_ex_rs1_data  = r_rs1_data;
  assign o_ex_rs2_data  = r_rs2_data;
  assign o_ex_imm       = r_imm;
  assign o_ex_rs1       = r_rs1;
  assign o_ex_rs2       = r_rs2;
  assign o_ex_rd        = r_rd;
  assign o_ex_funct3    = r_f3;
  assign o_ex_alu_ctrl  = r_ctrl.alu_ctrl;
  assign o_ex_alu_src_a = r_ctrl.alu_src_a;
  assign o_ex_alu_src_b = r_ctrl.alu_src_b;
  assign o_ex_reg_write = r_ctrl.reg_write;
  assign o_ex_mem_read  = r_ctrl.mem_read;
  assign o_ex_mem_write = r_ctrl.mem_write;
  assign o_ex_wb_sel    = r_ctrl.wb_sel;
  assign o_ex_branch    = r_ctrl.branch;
  assign o_ex_jump      = r_ctrl.jump;
  assign o_ex_jalr      = r_ctrl.jalr;
  assign o_ex_illegal   = r_ctrl.illegal;

  // Forced-zero source fields never match a nonzero rd, so unused sources cannot raise a hazard
  assign o_load_use = r_ctrl.mem_read && r_rd != '0 && (r_rd == w_rs1 || r_rd == w_rs2);
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized scoreboard bench for id_stage against an instruction-level reference model
module tb_id_stage;
  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5;
  localparam int K_ST = 6, K_OPI = 7, K_OP = 8, K_NOP = 9, K_BUB = 10, K_ILL = 11;

  typedef struct packed {
    logic [31:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        sa, sb, rw, mr, mw;
    logic [1:0]  wb;
    logic        br, j, jalr, ill;
  } exp_t;

  typedef struct {
    exp_t e;
    logic lu;
  } item_t;

  logic clk = 1'b0;
  logic i_rst = 1'b0, i_wb_reg_write = 1'b0, i_ex_stall = 1'b0, i_ex_flush = 1'b0;
  logic [31:0] i_id_pc = '0, i_id_pc_plus_4 = '0, i_id_instr = '0, i_wb_data = '0;
  logic [4:0]  i_wb_rd = '0;
  logic [31:0] o_ex_pc, o_ex_pc_plus_4, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm;
  logic [4:0]  o_ex_rs1, o_ex_rs2, o_ex_rd;
  logic [2:0]  o_ex_funct3;
  logic [3:0]  o_ex_alu_ctrl;
  logic        o_ex_alu_src_a, o_ex_alu_src_b, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write;
  logic [1:0]  o_ex_wb_sel;
  logic        o_ex_branch, o_ex_jump, o_ex_jalr, o_ex_illegal, o_load_use;

  int n_cmp = 0;
  int n_bad = 0;
  item_t q[$];
  exp_t m_ex;
  logic [31:0] m_rf [32];
  logic known = 1'b0;

  // {alt, funct3, alu code} per mnemonic
  int op_tab [10] = '{'h000, 'h101, 'h012, 'h023, 'h034, 'h045, 'h056, 'h157, 'h068, 'h079};
  int opi_tab [9] = '{'h000, 'h023, 'h034, 'h045, 'h068, 'h079, 'h012, 'h056, 'h157};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always #5 clk = ~clk;

  id_stage #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_id_pc(i_id_pc), .i_id_pc_plus_4(i_id_pc_plus_4), .i_id_instr(i_id_instr),
    .i_wb_reg_write(i_wb_reg_write), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_ex_stall(i_ex_stall), .i_ex_flush(i_ex_flush),
    .o_ex_pc(o_ex_pc), .o_ex_pc_plus_4(o_ex_pc_plus_4),
    .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm),
    .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd), .o_ex_funct3(o_ex_funct3),
    .o_ex_alu_ctrl(o_ex_alu_ctrl), .o_ex_alu_src_a(o_ex_alu_src_a), .o_ex_alu_src_b(o_ex_alu_src_b),
    .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read), .o_ex_mem_write(o_ex_mem_write),
    .o_ex_wb_sel(o_ex_wb_sel), .o_ex_branch(o_ex_branch), .o_ex_jump(o_ex_jump),
    .o_ex_jalr(o_ex_jalr), .o_ex_illegal(o_ex_illegal), .o_load_use(o_load_use)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_rf[a];
  endfunction

  // Assemble an instruction from semantic fields and state what it must decode to
  task automatic build(input int kind, input int sub, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] r, output logic [31:0] ins, output exp_t e);
    logic [20:0] jo;
    logic [12:0] bo;
    logic [11:0] i12;
    logic [2:0]  f3;
    int t;
    e = '0;
    ins = '0;
    i12 = r[11:0];
    jo = {r[19:0], 1'b0};
    bo = {r[11:0], 1'b0};
    case (kind)
      K_LUI, K_AUIPC: begin
        ins = {r[19:0], rd, (kind == K_LUI) ? 7'h37 : 7'h17};
        e.imm = {r[19:0], 12'h000};
        e.alu = (kind == K_LUI) ? 4'd10 : 4'd0;
        e.sa = kind == K_AUIPC;
        e.sb = 1'b1; e.rw = 1'b1; e.rd = rd;
      end
      K_JAL: begin
        ins = {jo[20], jo[10:1], jo[11], jo[19:12], rd, 7'h6F};
        e.imm = {{11{jo[20]}}, jo};
        e.j = 1'b1; e.rw = 1'b1; e.wb = 2'd2; e.sa = 1'b1; e.sb = 1'b1; e.rd = rd;
      end
      K_JALR: begin
        ins = {i12, rs1, 3'b000, rd, 7'h67};
        e.imm = {{20{i12[11]}}, i12};
        e.jalr = 1'b1; e.rw = 1'b1; e.wb = 2'd2; e.sb = 1'b1; e.rd = rd; e.rs1 = rs1;
      end
      K_BR: begin
        f3 = br_f3[sub % 6];
        ins = {bo[12], bo[10:5], rs2, rs1, f3, bo[4:1], bo[11], 7'h63};
        e.imm = {{19{bo[12]}}, bo};
        e.br = 1'b1; e.sa = 1'b1; e.sb = 1'b1; e.rs1 = rs1; e.rs2 = rs2;
      end
      K_LD: begin
        f3 = ld_f3[sub % 5];
        ins = {i12, rs1, f3, rd, 7'h03};
        e.imm = {{20{i12[11]}}, i12};
        e.mr = 1'b1; e.rw = 1'b1; e.wb = 2'd1; e.sb = 1'b1; e.rd = rd; e.rs1 = rs1;
      end
      K_ST: begin
        f3 = 3'(sub % 3);
        ins = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
        e.imm = {{20{i12[11]}}, i12};
        e.mw = 1'b1; e.sb = 1'b1; e.rs1 = rs1; e.rs2 = rs2;
      end
      K_OPI: begin
        t = opi_tab[sub % 9];
        f3 = t[6:4];
        if (f3 == 3'd1 || f3 == 3'd5) i12 = {1'b0, t[8], 5'b0, r[4:0]};
        ins = {i12, rs1, f3, rd, 7'h13};
        e.imm = {{20{i12[11]}}, i12};
        e.alu = t[3:0]; e.rw = 1'b1; e.sb = 1'b1; e.rd = rd; e.rs1 = rs1;
      end
      K_OP: begin
        t = op_tab[sub % 10];
        ins = {1'b0, t[8], 5'b0, rs2, rs1, t[6:4], rd, 7'h33};
        e.alu = t[3:0]; e.rw = 1'b1; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      end
      K_NOP: ins = (sub % 3 == 0) ? {r[31:20], 20'h0000F} : (sub % 3 == 1) ? 32'h0000_0073 : 32'h0010_0073;
      K_BUB: ins = 32'h0;
      default: begin
        case (sub % 4)
          0:       ins = {r[24:0], 7'h7F};
          1:       ins = {7'h01, rs2, rs1, r[2:0], rd, 7'h33};
          2:       ins = {i12, rs1, 3'b011, rd, 7'h03};
          default: ins = {r[31:15], 3'b010, r[11:7], 7'h63};
        endcase
        e.ill = 1'b1;
      end
    endcase
    e.f3 = ins[14:12];
  endtask

  // Drive one cycle of inputs, queue what the DUT must show this cycle, then advance the model
  task automatic issue(input logic [31:0] ins, input exp_t d, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wdat, input logic st, input logic fl, input logic rs);
    exp_t n;
    item_t it;
    @(posedge clk);
    #1;
    n = d;
    i_rst = rs; i_ex_stall = st; i_ex_flush = fl;
    i_wb_reg_write = we; i_wb_rd = wrd; i_wb_data = wdat;
    i_id_instr = ins;
    i_id_pc = $urandom;
    i_id_pc_plus_4 = i_id_pc + 32'd4;
    n.pc = i_id_pc;
    n.pc4 = i_id_pc_plus_4;
    n.rs1d = rf_read(n.rs1, we, wrd, wdat);
    n.rs2d = rf_read(n.rs2, we, wrd, wdat);
    if (known) begin
      it.e = m_ex;
      it.lu = m_ex.mr && m_ex.rd != 5'd0 && (m_ex.rd == n.rs1 || m_ex.rd == n.rs2);
      q.push_back(it);
    end
    if (rs) begin
      m_ex = '0;
      for (int k = 0; k < 32; k++) m_rf[k] = '0;
      known = 1'b1;
    end else begin
      if (fl) m_ex = '0;
      else if (!st) m_ex = n;
      if (we && wrd != 5'd0) m_rf[wrd] = wdat;
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("pc", o_ex_pc, it.e.pc);
        chk("pc4", o_ex_pc_plus_4, it.e.pc4);
        chk("rs1_data", o_ex_rs1_data, it.e.rs1d);
        chk("rs2_data", o_ex_rs2_data, it.e.rs2d);
        chk("imm", o_ex_imm, it.e.imm);
        chk("rs1", 32'(o_ex_rs1), 32'(it.e.rs1));
        chk("rs2", 32'(o_ex_rs2), 32'(it.e.rs2));
        chk("rd", 32'(o_ex_rd), 32'(it.e.rd));
        chk("funct3", 32'(o_ex_funct3), 32'(it.e.f3));
        chk("alu_ctrl", 32'(o_ex_alu_ctrl), 32'(it.e.alu));
        chk("alu_src_a", 32'(o_ex_alu_src_a), 32'(it.e.sa));
        chk("alu_src_b", 32'(o_ex_alu_src_b), 32'(it.e.sb));
        chk("reg_write", 32'(o_ex_reg_write), 32'(it.e.rw));
        chk("mem_read", 32'(o_ex_mem_read), 32'(it.e.mr));
        chk("mem_write", 32'(o_ex_mem_write), 32'(it.e.mw));
        chk("wb_sel", 32'(o_ex_wb_sel), 32'(it.e.wb));
        chk("branch", 32'(o_ex_branch), 32'(it.e.br));
        chk("jump", 32'(o_ex_jump), 32'(it.e.j));
        chk("jalr", 32'(o_ex_jalr), 32'(it.e.jalr));
        chk("illegal", 32'(o_ex_illegal), 32'(it.e.ill));
        chk("load_use", 32'(o_load_use), 32'(it.lu));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ins, b_ins;
    exp_t d, b_d;
    build(K_BUB, 0, 0, 0, 0, 0, b_ins, b_d);
    issue(b_ins, b_d, 0, 0, 0, 0, 0, 1);
    issue(b_ins, b_d, 1, 5'd9, 32'h1111_1111, 0, 0, 1);
    issue(b_ins, b_d, 1, 5'd5, 32'h1234_5678, 0, 0, 0);
    build(K_OP, 0, 6, 5, 0, 0, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    build(K_OP, 0, 8, 7, 0, 0, ins, d);
    issue(ins, d, 1, 5'd7, 32'hDEAD_BEEF, 0, 0, 0);
    @(negedge clk);
    chk("add_x6_rs1_data", o_ex_rs1_data, 32'h1234_5678);
    chk("add_x6_alu", 32'(o_ex_alu_ctrl), 32'd0);
    chk("add_x6_reg_write", 32'(o_ex_reg_write), 32'd1);
    chk("add_x6_rd", 32'(o_ex_rd), 32'd6);
    build(K_OP, 0, 9, 0, 0, 0, ins, d);
    issue(ins, d, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    @(negedge clk);
    chk("bypass_x7", o_ex_rs1_data, 32'hDEAD_BEEF);
    build(K_BR, 0, 0, 0, 0, 32'hFFE, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_reads_zero", o_ex_rs1_data, 32'h0);
    build(K_LD, 2, 3, 1, 0, 0, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("beq_imm", o_ex_imm, 32'hFFFF_FFFC);
    chk("beq_branch", 32'(o_ex_branch), 32'd1);
    chk("beq_reg_write", 32'(o_ex_reg_write), 32'd0);
    chk("beq_rd", 32'(o_ex_rd), 32'd0);
    build(K_OP, 0, 4, 3, 1, 0, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("load_use_hit", 32'(o_load_use), 32'd1);
    build(K_LD, 2, 3, 1, 0, 0, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    build(K_OPI, 0, 4, 0, 0, 1, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("load_use_none", 32'(o_load_use), 32'd0);
    build(K_OP, 0, 2, 1, 1, 0, ins, d);
    issue(ins, d, 0, 0, 0, 1, 1, 0);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush_reg_write", 32'(o_ex_reg_write), 32'd0);
    chk("flush_pc", o_ex_pc, 32'd0);
    build(K_OP, 0, 6, 5, 0, 0, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    build(K_OP, 1, 10, 2, 3, 0, ins, d);
    issue(ins, d, 0, 0, 0, 1, 0, 0);
    issue(ins, d, 0, 0, 0, 1, 0, 0);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stall_hold_rd", 32'(o_ex_rd), 32'd6);
    build(K_ILL, 0, 0, 0, 0, 0, ins, d);
    issue(ins, d, 0, 0, 0, 0, 0, 0);
    issue(b_ins, b_d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("illegal_7f", 32'(o_ex_illegal), 32'd1);
    chk("illegal_7f_reg_write", 32'(o_ex_reg_write), 32'd0);
    issue(b_ins, b_d, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bubble_not_illegal", 32'(o_ex_illegal), 32'd0);
    for (int c = 0; c < 3000; c++) begin
      build($urandom_range(0, 11), $urandom_range(0, 999), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, ins, d);
      issue(ins, d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    issue(b_ins, b_d, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
